// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 checker: folds payload bytes through a byte-wise LUT while the
// last four bytes sit in a delay line, then compares them against the computed CRC.
module crc32_frame_checker #(
    parameter logic [31:0] POLY     = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT   = 32'h00000000,
    parameter int          LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_short,
    output logic [31:0]      res_crc,
    output logic [LEN_W-1:0] res_len
);

    localparam logic [0:0] ST_RX  = 1'b0;
    localparam logic [0:0] ST_RES = 1'b1;

    function automatic logic [31:0] crc_entry(input int idx);
        logic [31:0] c;
        c = 32'(idx) << 24;
        for (int k = 0; k < 8; k++) begin
            c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    logic [31:0] crc_tbl [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_tbl
        assign crc_tbl[gi] = crc_entry(gi);
    end

    logic [0:0]        state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [3:0][7:0]   dl_q, dl_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              res_ok_q, res_ok_d;
    logic              res_short_q, res_short_d;
    logic [31:0]       res_crc_q, res_crc_d;
    logic [LEN_W-1:0]  res_len_q, res_len_d;

    logic              fold;
    logic [31:0]       crc_fold, crc_upd, crc_out, rx_crc;
    logic [LEN_W-1:0]  len_upd;

    // A byte is folded only once four newer bytes are behind it, so the trailing
    // four bytes of the frame never reach the CRC register.
    assign fold     = (cnt_q == 3'd4);
    assign crc_fold = (crc_q << 8) ^ crc_tbl[crc_q[31:24] ^ dl_q[3]];
    assign crc_upd  = fold ? crc_fold : crc_q;
    assign len_upd  = (fold && (len_q != '1)) ? LEN_W'(len_q + 1'b1) : len_q;
    assign crc_out  = crc_upd ^ XOROUT;
    assign rx_crc   = {dl_q[2], dl_q[1], dl_q[0], s_data};

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        dl_d        = dl_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        res_ok_d    = res_ok_q;
        res_short_d = res_short_q;
        res_crc_d   = res_crc_q;
        res_len_d   = res_len_q;
        if (state_q == ST_RX) begin
            if (s_valid) begin
                dl_d  = {dl_q[2:0], s_data};
                crc_d = crc_upd;
                len_d = len_upd;
                cnt_d = fold ? 3'd4 : cnt_q + 3'd1;
                if (s_last) begin
                    // No fold on the last byte means the frame held no payload (< 5 bytes).
                    res_short_d = !fold;
                    res_ok_d    = fold && (crc_out == rx_crc);
                    res_crc_d   = crc_out;
                    res_len_d   = fold ? len_upd : '0;
                    crc_d       = CRC_INIT;
                    cnt_d       = 3'd0;
                    len_d       = '0;
                    state_d     = ST_RES;
                end
            end
        end else begin
            if (res_ready) begin
                state_d = ST_RX;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RX;
            crc_q       <= CRC_INIT;
            dl_q        <= '0;
            cnt_q       <= 3'd0;
            len_q       <= '0;
            res_ok_q    <= 1'b0;
            res_short_q <= 1'b0;
            res_crc_q   <= 32'h0;
            res_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            dl_q        <= dl_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            res_ok_q    <= res_ok_d;
            res_short_q <= res_short_d;
            res_crc_q   <= res_crc_d;
            res_len_q   <= res_len_d;
        end
    end

    assign s_ready   = (state_q == ST_RX);
    assign res_valid = (state_q == ST_RES);
    assign res_ok    = res_ok_q;
    assign res_short = res_short_q;
    assign res_crc   = res_crc_q;
    assign res_len   = res_len_q;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Directed + randomized bench for crc32_frame_checker; expected verdicts come from a
// bit-serial CRC model over the queued frame bytes.
module tb_crc32_frame_checker;

    localparam logic [31:0] POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] XOROUT   = 32'h00000000;
    localparam int          LEN_W    = 16;

    logic             clk;
    logic             rstn;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             res_valid;
    logic             res_ready;
    logic             res_ok;
    logic             res_short;
    logic [31:0]      res_crc;
    logic [LEN_W-1:0] res_len;

    crc32_frame_checker #(
        .POLY(POLY), .CRC_INIT(CRC_INIT), .XOROUT(XOROUT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
        .res_short(res_short), .res_crc(res_crc), .res_len(res_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles = 0;
    logic [7:0] frame_q [$];

    logic             exp_ok, exp_short;
    logic [31:0]      exp_crc, exp_rx;
    logic [LEN_W-1:0] exp_len;

    always @(posedge clk) if (rstn && res_valid) valid_cycles++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_crc(input int nbytes);
        logic [31:0] c;
        c = CRC_INIT;
        for (int i = 0; i < nbytes; i++) begin
            c = c ^ ({24'h0, frame_q[i]} << 24);
            for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    task automatic model_frame();
        int n;
        n = frame_q.size();
        exp_short = (n < 5);
        exp_len   = exp_short ? '0 : LEN_W'(n - 4);
        exp_crc   = model_crc((n < 4) ? 0 : n - 4) ^ XOROUT;
        exp_rx    = (n >= 4) ? {frame_q[n-4], frame_q[n-3], frame_q[n-2], frame_q[n-1]} : 32'h0;
        exp_ok    = !exp_short && (exp_crc == exp_rx);
    endtask

    task automatic load_check_string();
        frame_q.delete();
        for (int i = 0; i < 9; i++) frame_q.push_back(8'(8'h31 + i));
    endtask

    task automatic append_crc();
        logic [31:0] c;
        c = model_crc(frame_q.size()) ^ XOROUT;
        frame_q.push_back(c[31:24]);
        frame_q.push_back(c[23:16]);
        frame_q.push_back(c[15:8]);
        frame_q.push_back(c[7:0]);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("s_ready_wait", s_ready, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        int gap;
        for (int i = 0; i < frame_q.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            send_byte(frame_q[i], i == frame_q.size() - 1);
        end
    endtask

    task automatic check_verdict(input string tag);
        model_frame();
        $display("frame %s: len=%0d crc=%08h ok=%0b short=%0b (expect len=%0d crc=%08h ok=%0b short=%0b)",
                 tag, res_len, res_crc, res_ok, res_short, exp_len, exp_crc, exp_ok, exp_short);
        check({tag, ".res_valid"}, res_valid, 1'b1);
        check({tag, ".res_ok"},    res_ok,    exp_ok);
        check({tag, ".res_short"}, res_short, exp_short);
        check({tag, ".res_crc"},   res_crc,   exp_crc);
        check({tag, ".res_len"},   res_len,   exp_len);
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, ".valid_after_hs"}, res_valid, 1'b0);
        check({tag, ".ready_after_hs"}, s_ready,   1'b1);
    endtask

    initial begin
        int v0;
        rstn = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.s_ready",   s_ready,   1'b1);
        check("rst.res_valid", res_valid, 1'b0);
        check("rst.res_ok",    res_ok,    1'b0);
        check("rst.res_short", res_short, 1'b0);
        check("rst.res_crc",   res_crc,   32'h0);
        check("rst.res_len",   res_len,   16'h0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Reference frame, back-to-back
        load_check_string();
        append_crc();
        check("ref.trailer", {frame_q[9], frame_q[10], frame_q[11], frame_q[12]}, 32'h0376E6E7);
        send_frame(0);
        check_verdict("good");
        check("good.crc_const", res_crc, 32'h0376E6E7);
        check("good.len_const", res_len, 16'd9);
        check("good.ok_const",  res_ok,  1'b1);
        consume("good");

        // Corrupted payload byte
        frame_q[4] = 8'h36;
        send_frame(0);
        check_verdict("bad5");
        check("bad5.ok_const", res_ok, 1'b0);
        check("bad5.crc_differs", (res_crc != 32'h0376E6E7), 1'b1);
        consume("bad5");

        // Short frames, then re-arm
        frame_q.delete();
        frame_q.push_back(8'($urandom));
        send_frame(0);
        check_verdict("short1");
        check("short1.short_const", res_short, 1'b1);
        consume("short1");
        frame_q.delete();
        for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom));
        send_frame(0);
        check_verdict("short4");
        check("short4.len_const", res_len, 16'd0);
        consume("short4");
        load_check_string();
        append_crc();
        send_frame(0);
        check_verdict("rearm");
        check("rearm.ok_const", res_ok, 1'b1);
        consume("rearm");

        // Gapped input, result held for 5 cycles
        send_frame(3);
        check_verdict("gaps");
        check("gaps.ready_low", s_ready, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
            check_verdict("gaps_hold");
            check("gaps_hold.ready_low", s_ready, 1'b0);
        end
        consume("gaps");

        // Two frames with res_ready held high
        res_ready = 1'b1;
        v0 = valid_cycles;
        send_frame(0);
        check_verdict("b2b_a");
        frame_q.delete();
        for (int i = 0; i < 7; i++) frame_q.push_back(8'($urandom));
        append_crc();
        send_frame(0);
        check_verdict("b2b_b");
        check("b2b_b.ok_const", res_ok, 1'b1);
        @(posedge clk); #1;
        check("b2b.valid_drop", res_valid, 1'b0);
        check("b2b.pulses", 64'(valid_cycles - v0), 64'd2);
        res_ready = 1'b0;

        // Randomized frames: good, corrupted and short
        for (int f = 0; f < 10; f++) begin
            frame_q.delete();
            if (f % 4 == 3) begin
                repeat ($urandom_range(1, 4)) frame_q.push_back(8'($urandom));
            end else begin
                repeat ($urandom_range(1, 24)) frame_q.push_back(8'($urandom));
                append_crc();
                if ($urandom_range(0, 1) == 1) begin
                    int idx;
                    idx = int'($urandom_range(0, frame_q.size() - 1));
                    frame_q[idx] = frame_q[idx] ^ 8'(1 << $urandom_range(0, 7));
                end
            end
            send_frame(2);
            check_verdict($sformatf("rand%0d", f));
            consume($sformatf("rand%0d", f));
        end

        // Reset mid-frame
        load_check_string();
        append_crc();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1'b0);
        rstn = 1'b0;
        #2;
        check("abort.valid_in_rst", res_valid, 1'b0);
        check("abort.ready_in_rst", s_ready,   1'b1);
        check("abort.len_in_rst",   res_len,   16'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort.no_verdict", res_valid, 1'b0);
        send_frame(0);
        check_verdict("after_abort");
        check("after_abort.len_const", res_len, 16'd9);
        check("after_abort.ok_const",  res_ok,  1'b1);
        consume("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
